// File: rtl/coreport_pkg.sv
// Shared constants for the GPIO port input conditioning stage.
package coreport_pkg;
    localparam int COREPORT_WIDTH       = 32;
    localparam int COREPORT_SYNC_STAGES = 2;
    localparam int COREPORT_DB_CNT_W    = 8;
    localparam int COREPORT_PRESC_W     = 16;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;
endpackage

// File: rtl/coreport_debounce.sv
// One pin: synchroniser, tick-qualified debounce filter and delayed level for edge detection.
// Latency SYNC_STAGES cycles in bypass; no backpressure.
module coreport_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             pin_i,
    input  logic             db_en_i,
    input  logic [CNT_W-1:0] db_len_i,
    input  logic             tick_i,
    output logic             pin_o,
    output logic             pin_d_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   pin_d_q;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // cnt only advances while the synchronised level disagrees with the output,
    // and is bounded by db_len_i so it cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!db_en_i) begin
            cnt_d = '0;
            lvl_d = sync;
        end else if (sync == lvl_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q >= db_len_i) begin
                lvl_d = sync;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            pin_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pin_d_q <= lvl_q;
        end
    end

    assign pin_o   = lvl_q;
    assign pin_d_o = pin_d_q;
endmodule

// File: rtl/coreport_incond.sv
// GPIO input conditioning: per-pin sync + debounce, shared prescaler, registered edge/event pulses.
// Events lag pin_o by one cycle; fire-and-forget, no backpressure.
module coreport_incond
    import coreport_pkg::*;
#(
    parameter int WIDTH       = COREPORT_WIDTH,
    parameter int SYNC_STAGES = COREPORT_SYNC_STAGES,
    parameter int CNT_W       = COREPORT_DB_CNT_W,
    parameter int PRESC_W     = COREPORT_PRESC_W
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [WIDTH-1:0]   pin_i,
    input  logic [WIDTH-1:0]   db_en_i,
    input  logic [CNT_W-1:0]   db_len_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [WIDTH-1:0]   edge_sel_i,
    input  logic [WIDTH-1:0]   edge_both_i,
    output logic [WIDTH-1:0]   pin_o,
    output logic [WIDTH-1:0]   rise_o,
    output logic [WIDTH-1:0]   fall_o,
    output logic [WIDTH-1:0]   evt_o
);
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               tick;
    logic [WIDTH-1:0]   pin_d;
    logic [WIDTH-1:0]   rise_d, fall_d, evt_d;
    logic [WIDTH-1:0]   rise_q, fall_q, evt_q;

    // >= rather than == so lowering presc_i below pcnt wraps immediately.
    assign tick   = (pcnt_q >= presc_i);
    assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        coreport_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_db (
            .wb_clk   (wb_clk),
            .wb_rst   (wb_rst),
            .pin_i    (pin_i[i]),
            .db_en_i  (db_en_i[i]),
            .db_len_i (db_len_i),
            .tick_i   (tick),
            .pin_o    (pin_o[i]),
            .pin_d_o  (pin_d[i])
        );
    end

    always_comb begin
        rise_d = pin_o & ~pin_d;
        fall_d = ~pin_o & pin_d;
        evt_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (edge_both_i[i])
                evt_d[i] = rise_d[i] | fall_d[i];
            else if (edge_sel_i[i] == EDGE_FALL)
                evt_d[i] = fall_d[i];
            else
                evt_d[i] = rise_d[i];
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            pcnt_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign evt_o  = evt_q;
endmodule

// File: doc/coreport_incond.md
# coreport_incond

Input conditioning stage for the GPIO port peripheral. It sits between the physical pin inputs and the port's data and interrupt-flag logic. For each pin it synchronises the raw level, optionally debounces it against a prescaled time base, and emits single-cycle rising, falling and selected-edge event pulses. The port consumes the clean level for DATAR reads and the event pulses to set IFR bits.

## Interface
Parameters:
- `WIDTH`, 32, number of pins
- `SYNC_STAGES`, 2, synchroniser depth (legal ≥2)
- `CNT_W`, 8, debounce counter width
- `PRESC_W`, 16, prescaler width

Ports:
- `wb_clk` in 1: the single clock.
- `wb_rst` in 1: reset, synchronous and active-high.
- `pin_i` in WIDTH: raw asynchronous pin levels.
- `db_en_i` in WIDTH: per-pin debounce enable.
- `db_len_i` in CNT_W: required stable ticks minus one.
- `presc_i` in PRESC_W: tick divisor minus one.
- `edge_sel_i` in WIDTH: per-pin edge select for events, 0 = rising, 1 = falling.
- `edge_both_i` in WIDTH: per-pin flag; when 1, both edges produce events and `edge_sel_i` is ignored.
- `pin_o` out WIDTH: conditioned level.
- `rise_o` out WIDTH: one-cycle pulse on a 0→1 transition of `pin_o`.
- `fall_o` out WIDTH: one-cycle pulse on a 1→0 transition of `pin_o`.
- `evt_o` out WIDTH: one-cycle selected-edge pulse, feeds IFR set.

## Operation
- **Synchroniser:** a SYNC_STAGES flop chain per pin. All stages reset to 0. `sync[i]` is the last stage.
- **Prescaler:** a counter `pcnt`.
  - `tick = (pcnt >= presc_i)`.
  - On tick, `pcnt` returns to 0; otherwise it increments.
  - `presc_i = 0` gives a tick every cycle.
  - If `presc_i` is lowered below `pcnt`, the next cycle ticks and wraps, so no long stall occurs.
- **Debounce, per pin, `db_en_i[i] = 1`:**
  - If `sync == pin_o`, `cnt` is cleared to 0.
  - Else, on a tick: if `cnt >= db_len_i`, then `pin_o <= sync` and `cnt <= 0`; otherwise `cnt <= cnt + 1`.
  - Else, with no tick, `cnt` holds.
  - Net effect: `pin_o` changes on the (db_len_i+1)-th consecutive tick with a mismatch.
  - A mismatch that ends before then is discarded, so a glitch leaves `pin_o` unchanged.
  - `cnt` never exceeds `db_len_i`, so it cannot wrap.
- **Debounce bypassed, `db_en_i[i] = 0`:** `pin_o[i] <= sync[i]` every cycle, and `cnt` is held at 0.
- **Toggling `db_en_i` mid-count:** `cnt` clears and no spurious edge is generated. Changing `db_len_i` mid-count takes effect at the next comparison.
- **Edge detection:** `pin_d <= pin_o`.
  - `rise_o <= pin_o & ~pin_d` (registered).
  - `fall_o <= ~pin_o & pin_d` (registered).
  - `evt_o <= edge_both_i ? (rise|fall) : (edge_sel_i ? fall : rise)`, computed from the same-cycle values.
  - Every pulse is exactly one cycle long. Edges on different pins are independent and may pulse in the same cycle.
- **Reset:** all synchroniser stages, `pin_o`, `pin_d`, `cnt`, `pcnt`, `rise_o`, `fall_o` and `evt_o` reset to 0.
  - A pin held high through reset produces a rising edge and event after release. This is intended; firmware clears IFR after enabling IMR.
  - Asserting `wb_rst` mid-debounce aborts the count.

## Timing
- Edge 0 is the first `wb_clk` edge at which a new `pin_i` level is sampled.
- Bypass: `pin_o` updates at edge SYNC_STAGES. Example: with SYNC_STAGES=2, after 3 edges (edges 0,1,2).
- Bypass events: `rise_o`, `fall_o` and `evt_o` pulse one cycle later, at edge SYNC_STAGES+1.
- Debounce, `presc_i = 0`: `pin_o` updates at edge SYNC_STAGES+db_len_i. With `db_len_i = 0` this equals bypass timing.
- Debounce, general: `pin_o` updates on the (db_len_i+1)-th qualifying tick after `sync` diverges.
- Throughput: one transition per pin per (db_len_i+1) ticks at most. There is no backpressure; every event pulse is fire-and-forget.

## Structure
- Shared package `coreport_pkg`:
  - default constants: `COREPORT_WIDTH = 32`, `COREPORT_SYNC_STAGES = 2`, `COREPORT_DB_CNT_W = 8`, `COREPORT_PRESC_W = 16`;
  - the edge-select encoding constants `EDGE_RISE = 0`, `EDGE_FALL = 1`.
- Sub-module `coreport_debounce`: a single pin containing the synchroniser, counter, `pin_o` and `pin_d`. It is instantiated WIDTH times in a generate loop.
- The prescaler and the edge/event output mux live in the top level.

## Test plan
- **Bypass latency.** Reset, `db_en_i = 0`, drive `pin_i[0]` 0→1. Expect `pin_o[0] = 1` at edge 2, then `rise_o[0]` and `evt_o[0]` high for exactly edge 3 only (`edge_sel_i = 0`), and `fall_o = 0`.
- **Debounce filtering.** `db_en_i = all ones`, `presc_i = 0`, `db_len_i = 3`.
  - A 3-cycle high glitch on `pin_i[5]` leaves `pin_o[5] = 0` with no events.
  - A steady high gives `pin_o[5] = 1` at edge 5.
- **Prescaled timing.** `presc_i = 4`, `db_len_i = 1`, pin 7 rises. Expect `pin_o[7]` on the second tick after divergence; tick spacing is measured at 5 cycles.
- **Edge select.**
  - `edge_sel_i[2] = 1`, pulse pin 2 high then low: `evt_o[2]` fires only on the fall.
  - `edge_both_i[2] = 1`: `evt_o[2]` fires on both edges, with 2 pulses total.
- **Simultaneous pins.** Drive all 32 pins 0→1 in the same cycle with bypass. Expect `rise_o = 32'hFFFF_FFFF` for one cycle.
- **Reset mid-count.**
  - `db_len_i = 10`: assert `wb_rst` for one cycle at `cnt = 6`. All outputs are 0 the next cycle and the count restarts from 0.
  - A pin held high through reset yields exactly one rising event.
